// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//   - READ_WRITE operation codes
//   - FSM state encoding (IDLE / ACCESS / DONE)
//   - Operation classification helpers (load/store/valid, access size, signedness)
package data_mem_responder_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_SB   = 4'b0001;
  localparam logic [3:0] OP_SH   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_LB   = 4'b1000;
  localparam logic [3:0] OP_LH   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_LBU  = 4'b1100;
  localparam logic [3:0] OP_LHU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Unlisted codes behave exactly like OP_NONE.
  function automatic logic is_valid_op(input logic [3:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic logic size_byte(input logic [3:0] op);
    return op inside {OP_SB, OP_LB, OP_LBU};
  endfunction

  function automatic logic size_half(input logic [3:0] op);
    return op inside {OP_SH, OP_LH, OP_LHU};
  endfunction

  function automatic logic size_word(input logic [3:0] op);
    return op inside {OP_SW, OP_LW};
  endfunction

  function automatic logic is_signed_load(input logic [3:0] op);
    return op inside {OP_LB, OP_LH};
  endfunction

endpackage

// File: rtl/data_mem_responder_load_extend_unit.sv
// Combinational load formatter.
// Ports:
//   rd_word  in  32  aligned memory word containing the addressed data
//   lane     in  2   ADDRESS[1:0] of the access
//   op       in  4   READ_WRITE code of the load
//   value    out 32  lane-selected, sign- or zero-extended load result
// Halfword lanes are chosen by lane[1] only and words ignore lane entirely,
// which gives the truncating behaviour for unaligned addresses.
module load_extend_unit
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [3:0]  op,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    value = '0;
    if (size_byte(op)) begin
      value = {{24{is_signed_load(op) & byte_sel[7]}}, byte_sel};
    end else if (size_half(op)) begin
      value = {{16{is_signed_load(op) & half_sel[15]}}, half_sel};
    end else if (size_word(op)) begin
      value = rd_word;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data memory interface.
// Multi-cycle, byte-addressed, little-endian data memory that stalls the
// pipeline through BUSYWAIT until each access completes.
// Ports:
//   CLK         in  1   clock, rising edge
//   RESET       in  1   synchronous active-low reset
//   READ_WRITE  in  4   operation code (see package)
//   ADDRESS     in  32  byte address; only the low ADDR_WIDTH bits decoded
//   WRITE_DATA  in  32  store data (low byte/halfword for SB/SH)
//   READ_DATA   out 32  registered, extended load result
//   BUSYWAIT    out 1   stall request to all pipeline registers
//   MISALIGNED  out 1   misaligned-access flag, high in DONE only
// Optional feature macro: DATA_MEM_MISALIGN_CHECK_EN
//   defined   - misaligned halfword/word accesses write nothing, return 0
//               and raise MISALIGNED during DONE
//   undefined - MISALIGNED tied to 0, low address bits truncated
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 4
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

  state_e                  state, next_state;
  logic [3:0]              cnt;
  logic [3:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             mem [WORDS];
  logic [31:0]             rd_word, load_value, wr_lanes;
  logic [3:0]              wr_be;
  logic                    req_valid, complete, misalign, do_write;
  logic                    unused_addr_hi;

  // Upper address bits alias onto the decoded range.
  assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH];

  assign req_valid = is_valid_op(READ_WRITE);
  assign complete  = (state == ST_ACCESS) && (cnt == 4'd0);

  always_ff @(posedge CLK) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (req_valid) next_state = ST_ACCESS;
      ST_ACCESS: if (cnt == 4'd0) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // IDLE stalls combinationally so the request cycle itself is held.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (RESET) begin
      case (state)
        ST_IDLE:   BUSYWAIT = req_valid;
        ST_ACCESS: BUSYWAIT = 1'b1;
        default:   BUSYWAIT = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt <= 4'd0;
    end else if (state == ST_IDLE && req_valid) begin
      cnt <= 4'(LATENCY - 1);
    end else if (state == ST_ACCESS && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request capture; only consulted while in ACCESS.
  always_ff @(posedge CLK) begin
    if (state == ST_IDLE && req_valid) begin
      op_q    <= READ_WRITE;
      addr_q  <= ADDRESS[ADDR_WIDTH-1:0];
      wdata_q <= WRITE_DATA;
    end
  end

`ifdef DATA_MEM_MISALIGN_CHECK_EN
  logic mis_q;

  assign misalign = (size_half(op_q) && addr_q[0]) ||
                    (size_word(op_q) && (addr_q[1:0] != 2'b00));

  always_ff @(posedge CLK) begin
    if (!RESET) mis_q <= 1'b0;
    else        mis_q <= complete && misalign;
  end

  assign MISALIGNED = mis_q;
`else
  assign misalign   = 1'b0;
  assign MISALIGNED = 1'b0;
`endif

  assign rd_word = mem[addr_q[ADDR_WIDTH-1:2]];

  load_extend_unit u_load_extend (
    .rd_word (rd_word),
    .lane    (addr_q[1:0]),
    .op      (op_q),
    .value   (load_value)
  );

  // Replicate store data across lanes; the byte enables pick the live ones.
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = wdata_q;
    if (size_byte(op_q)) begin
      wr_be    = 4'b0001 << addr_q[1:0];
      wr_lanes = {4{wdata_q[7:0]}};
    end else if (size_half(op_q)) begin
      wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      wr_lanes = {2{wdata_q[15:0]}};
    end else if (size_word(op_q)) begin
      wr_be    = 4'b1111;
    end
  end

  // Gating with RESET makes a reset on the completing edge abort the store.
  assign do_write = RESET && complete && is_store(op_q) && !misalign;

  always_ff @(posedge CLK) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[addr_q[ADDR_WIDTH-1:2]][8*k +: 8] <= wr_lanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      READ_DATA <= 32'd0;
    end else if (complete && is_load(op_q)) begin
      READ_DATA <= misalign ? 32'd0 : load_value;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (LATENCY=4, ADDR_WIDTH=12):
// directed vector table, reset/idle/re-execution sequences, and randomized
// traffic compared against a byte-array reference model.
module tb_data_mem_responder;

  localparam int AW  = 12;
  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  READ_WRITE;
  logic [31:0] ADDRESS, WRITE_DATA, READ_DATA;
  logic        BUSYWAIT, MISALIGNED;

  always #5 CLK = ~CLK;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .READ_WRITE (READ_WRITE),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSYWAIT   (BUSYWAIT),
    .MISALIGNED (MISALIGNED)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  byte unsigned ref_mem [4096];
  logic [31:0]  ref_rd;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] op);
    case (op)
      4'b0001, 4'b1000, 4'b1100: return 1;
      4'b0010, 4'b1001, 4'b1101: return 2;
      4'b0011, 4'b1010:          return 4;
      default:                   return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input logic [3:0] op);
    return op inside {4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
  endfunction

  function automatic bit op_is_signed(input logic [3:0] op);
    return op inside {4'b1000, 4'b1001};
  endfunction

  // Applies one request to the model; returns the expected MISALIGNED.
  task automatic model_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic exp_mis);
    int     sz;
    int     ea;
    longint v;
    exp_mis = 1'b0;
    sz = size_of(op);
    if (sz == 0) return;
    ea = int'(addr % (32'd1 << AW));
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    if ((ea % sz) != 0) begin
      exp_mis = 1'b1;
      if (op_is_load(op)) ref_rd = 32'd0;
      return;
    end
`else
    ea = ea - (ea % sz);
`endif
    if (op_is_load(op)) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v + (longint'(ref_mem[ea + i]) << (8 * i));
      if (op_is_signed(op) && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      ref_rd = 32'(v);
    end else begin
      for (int i = 0; i < sz; i++) ref_mem[ea + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    end
  endtask

  // Drives one request from a falling edge and follows it to its DONE cycle.
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit scramble,
                        output logic [31:0] rd, output int busy_n, output logic mis);
    @(negedge CLK);
    READ_WRITE = op;
    ADDRESS    = addr;
    WRITE_DATA = wdata;
    busy_n     = 0;
    #1;
    while (BUSYWAIT && busy_n < 40) begin
      busy_n++;
      @(negedge CLK);
      if (scramble && BUSYWAIT) begin
        READ_WRITE = 4'($urandom);
        ADDRESS    = $urandom;
        WRITE_DATA = $urandom;
      end
    end
    rd  = READ_DATA;
    mis = MISALIGNED;
    READ_WRITE = 4'b0000;
  endtask

  task automatic run_and_check(input string name, input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit scramble);
    logic [31:0] rd;
    int          busy_n;
    logic        mis, exp_mis;
    model_op(op, addr, wdata, exp_mis);
    do_req(op, addr, wdata, scramble, rd, busy_n, mis);
    check({name, ".busy"}, 32'(busy_n), (size_of(op) != 0) ? 32'(LAT + 1) : 32'd0);
    check({name, ".rd"},   rd, ref_rd);
    check({name, ".mis"},  32'(mis), 32'(exp_mis));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [11];
    logic [31:0] rd;
    int          busy_n;
    logic        mis, exp_mis;
    logic [3:0]  rops [10];

    tbl[0]  = '{4'b0011, 32'h10, 32'h12345678, 32'h00000000};
    tbl[1]  = '{4'b1010, 32'h10, 32'h0,        32'h12345678};
    tbl[2]  = '{4'b0001, 32'h11, 32'h000000AB, 32'h12345678};
    tbl[3]  = '{4'b1010, 32'h10, 32'h0,        32'h1234AB78};
    tbl[4]  = '{4'b1000, 32'h11, 32'h0,        32'hFFFFFFAB};
    tbl[5]  = '{4'b1100, 32'h11, 32'h0,        32'h000000AB};
    tbl[6]  = '{4'b0010, 32'h12, 32'h00008001, 32'h000000AB};
    tbl[7]  = '{4'b1001, 32'h12, 32'h0,        32'hFFFF8001};
    tbl[8]  = '{4'b1101, 32'h12, 32'h0,        32'h00008001};
    tbl[9]  = '{4'b1010, 32'h10, 32'h0,        32'h8001AB78};
    tbl[10] = '{4'b1010, 32'hABCD_F010, 32'h0, 32'h8001AB78};

    rops = '{4'b0001, 4'b0010, 4'b0011, 4'b1000, 4'b1001,
             4'b1010, 4'b1100, 4'b1101, 4'b0000, 4'b1111};

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    ref_rd = 32'd0;

    // Reset
    RESET = 1'b0; READ_WRITE = 4'b0011; ADDRESS = 32'h10; WRITE_DATA = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset.busy", 32'(BUSYWAIT), 32'd0);
    check("reset.rd",   READ_DATA, 32'd0);
    check("reset.mis",  32'(MISALIGNED), 32'd0);
    READ_WRITE = 4'b0000;
    @(negedge CLK);
    RESET = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      model_op(tbl[i].op, tbl[i].addr, tbl[i].wdata, exp_mis);
      do_req(tbl[i].op, tbl[i].addr, tbl[i].wdata, (i % 2) == 1, rd, busy_n, mis);
      check($sformatf("vec%0d.busy", i), 32'(busy_n), 32'(LAT + 1));
      check($sformatf("vec%0d.rd", i),   rd, tbl[i].exp_rd);
      check($sformatf("vec%0d.mis", i),  32'(mis), 32'd0);
    end

    // Idle and unlisted op codes
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      READ_WRITE = (c < 20) ? 4'b0000 : 4'b1111;
      ADDRESS = $urandom; WRITE_DATA = $urandom;
      #1;
      check($sformatf("idle%0d.busy", c), 32'(BUSYWAIT), 32'd0);
      check($sformatf("idle%0d.rd", c),   READ_DATA, 32'h8001AB78);
    end
    READ_WRITE = 4'b0000;

    // Misaligned word load and store
    do_req(4'b1010, 32'h13, 32'h0, 1'b0, rd, busy_n, mis);
`ifdef DATA_MEM_MISALIGN_CHECK_EN
    check("mis_lw.rd",  rd, 32'd0);
    check("mis_lw.mis", 32'(mis), 32'd1);
    ref_rd = 32'd0;
    do_req(4'b0011, 32'h13, 32'hCAFEBABE, 1'b0, rd, busy_n, mis);
    check("mis_sw.mis", 32'(mis), 32'd1);
    do_req(4'b1010, 32'h10, 32'h0, 1'b0, rd, busy_n, mis);
    check("mis_sw.unchanged", rd, 32'h8001AB78);
    check("mis_sw.mis_clear", 32'(mis), 32'd0);
    ref_rd = 32'h8001AB78;
`else
    check("mis_lw.rd",  rd, 32'h8001AB78);
    check("mis_lw.mis", 32'(mis), 32'd0);
`endif
    check("mis_lw.busy", 32'(busy_n), 32'(LAT + 1));

    // Request held after DONE re-executes
    do_req(4'b1100, 32'h12, 32'h0, 1'b0, rd, busy_n, mis);
    check("rerun.first", rd, 32'h00000001);
    READ_WRITE = 4'b1100;
    #1;
    @(negedge CLK);
    #1;
    check("rerun.busy_idle", 32'(BUSYWAIT), 32'd1);
    busy_n = 0;
    while (BUSYWAIT && busy_n < 40) begin
      busy_n++;
      @(negedge CLK);
    end
    READ_WRITE = 4'b0000;
    check("rerun.busy_len", 32'(busy_n), 32'(LAT + 1));
    check("rerun.rd", READ_DATA, 32'h00000001);
    ref_rd = 32'h00000001;

    // Reset during the third ACCESS cycle aborts a store
    run_and_check("pre_sw", 4'b0011, 32'h20, 32'h11223344, 1'b0);
    @(negedge CLK);
    READ_WRITE = 4'b0011; ADDRESS = 32'h20; WRITE_DATA = 32'hDEADBEEF;
    repeat (3) @(negedge CLK);
    #1;
    check("abort.busy_access", 32'(BUSYWAIT), 32'd1);
    RESET = 1'b0; READ_WRITE = 4'b0000;
    #1;
    check("abort.busy_in_reset", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("abort.busy", 32'(BUSYWAIT), 32'd0);
    check("abort.rd",   READ_DATA, 32'd0);
    check("abort.mis",  32'(MISALIGNED), 32'd0);
    ref_rd = 32'd0;
    do_req(4'b1010, 32'h20, 32'h0, 1'b0, rd, busy_n, mis);
    check("abort.old_contents", rd, 32'h11223344);
    ref_rd = 32'h11223344;

    // Randomized traffic in a 64-byte window with aliased upper address bits
    for (int w = 0; w < 16; w++)
      run_and_check($sformatf("init%0d", w), 4'b0011, 32'h100 + 32'(4 * w), $urandom, 1'b0);
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      op   = rops[$urandom_range(0, 9)];
      addr = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
      run_and_check($sformatf("rnd%0d", n), op, addr, $urandom, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
